// File: rtl/reset_sequencer.sv
// Reset request arbiter and sequencer: grants the highest-priority request, then drives
// staggered active-low peripheral/core resets followed by a holdoff window.
module reset_sequencer #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned PULSE_CYCLES   = 100,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned HOLDOFF_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           req_ack,
  output logic                       periph_rst_n,
  output logic                       core_rst_n,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   cause,
  output logic [7:0]                 reset_count
);

  localparam int unsigned CauseW = $clog2(N_REQ);
  localparam int unsigned MaxPs  = (PULSE_CYCLES > STAGGER_CYCLES) ? PULSE_CYCLES
                                                                   : STAGGER_CYCLES;
  localparam int unsigned MaxLen = (MaxPs > HOLDOFF_CYCLES) ? MaxPs : HOLDOFF_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  localparam logic [CntW-1:0] PulseLast   = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] StaggerLast = CntW'(STAGGER_CYCLES - 1);
  localparam logic [CntW-1:0] HoldoffLast = CntW'(HOLDOFF_CYCLES - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAssert  = 2'd1;
  localparam logic [1:0] StStagger = 2'd2;
  localparam logic [1:0] StHoldoff = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [CauseW-1:0] cause_q, cause_d;
  logic [7:0]        count_q, count_d;
  logic              periph_q, periph_d;
  logic              core_q, core_d;
  logic              busy_q, busy_d;

  logic [N_REQ-1:0]  cand;
  logic [N_REQ-1:0]  grant_oh;
  logic [CauseW-1:0] grant_idx;
  logic              found;

  // Lowest set index of req|pending wins.
  always_comb begin
    cand      = req | pending_q;
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (cand[i] && !found) begin
        found       = 1'b1;
        grant_idx   = i[CauseW-1:0];
        grant_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    pending_d = pending_q | req;
    ack_d     = '0;
    cause_d   = cause_q;
    count_d   = count_q;
    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        pending_d = cand & ~grant_oh;
        if (found) begin
          state_d = StAssert;
          ack_d   = grant_oh;
          cause_d = grant_idx;
          count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        end
      end
      StAssert: begin
        if (cnt_q == PulseLast) begin
          state_d = StStagger;
          cnt_d   = '0;
        end
      end
      StStagger: begin
        if (cnt_q == StaggerLast) begin
          state_d = StHoldoff;
          cnt_d   = '0;
        end
      end
      StHoldoff: begin
        if (cnt_q == HoldoffLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered, so decode them from the next state.
    periph_d = (state_d != StAssert);
    core_d   = (state_d == StIdle) || (state_d == StHoldoff);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pending_q <= '0;
      ack_q     <= '0;
      cause_q   <= '0;
      count_q   <= '0;
      periph_q  <= 1'b1;
      core_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      cause_q   <= cause_d;
      count_q   <= count_d;
      periph_q  <= periph_d;
      core_q    <= core_d;
      busy_q    <= busy_d;
    end
  end

  assign req_ack      = ack_q;
  assign periph_rst_n = periph_q;
  assign core_rst_n   = core_q;
  assign busy         = busy_q;
  assign cause        = cause_q;
  assign reset_count  = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with PULSE=4, STAGGER=2, HOLDOFF=3.
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_ack;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic       busy;
  logic [1:0] cause;
  logic [7:0] reset_count;

  int n_cmp;
  int n_err;

  reset_sequencer #(
    .N_REQ          (4),
    .PULSE_CYCLES   (4),
    .STAGGER_CYCLES (2),
    .HOLDOFF_CYCLES (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_ack      (req_ack),
    .periph_rst_n (periph_rst_n),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .cause        (cause),
    .reset_count  (reset_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // Called on the first cycle after a grant; walks the 9 busy cycles and ends on the
  // first IDLE cycle. inj is OR-ed onto req for one cycle during ASSERT.
  task automatic check_seq(input int exp_cause, input int exp_count, input logic [3:0] inj);
    for (int k = 1; k <= 9; k++) begin
      check("ack", req_ack, (k == 1) ? (32'd1 << exp_cause) : 32'd0);
      check("cause", cause, exp_cause);
      check("count", reset_count, exp_count);
      check("periph", periph_rst_n, k > 4);
      check("core", core_rst_n, k > 6);
      check("busy", busy, 1);
      if (k == 1) req = req | inj;
      else if (k == 2) req = req & ~inj;
      step();
    end
    check("idle_busy", busy, 0);
    check("idle_periph", periph_rst_n, 1);
    check("idle_core", core_rst_n, 1);
    check("idle_ack", req_ack, 0);
    check("idle_cause", cause, exp_cause);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    repeat (3) step();
    check("rst_ack", req_ack, 0);
    check("rst_periph", periph_rst_n, 1);
    check("rst_core", core_rst_n, 1);
    check("rst_busy", busy, 0);
    check("rst_cause", cause, 0);
    check("rst_count", reset_count, 0);
    rst = 1'b0;

    // Single pulse request from source 2.
    req = 4'b0100;
    step();
    req = 4'b0000;
    check_seq(2, 1, 4'b0000);

    // Two simultaneous requests: 1 first, 3 follows without a new request.
    do_reset();
    req = 4'b1010;
    step();
    req = 4'b0000;
    check_seq(1, 1, 4'b0000);
    step();
    check_seq(3, 2, 4'b0000);
    step();
    check("no_more_ack", req_ack, 0);
    check("no_more_busy", busy, 0);

    // Request 0 pulsed mid-ASSERT does not disturb the running sequence.
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b0000;
    check_seq(2, 1, 4'b0001);
    step();
    check_seq(0, 2, 4'b0000);

    // Stuck request: back-to-back sequences and saturating count.
    do_reset();
    req = 4'b1000;
    step();
    for (int s = 1; s <= 256; s++) begin
      check_seq(3, (s > 255) ? 255 : s, 4'b0000);
      step();
    end
    req = 4'b0000;

    // Reset in STAGGER with a request pending aborts and clears everything.
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b0010;
    step();
    req = 4'b0000;
    repeat (3) step();
    check("stg_periph", periph_rst_n, 1);
    check("stg_core", core_rst_n, 0);
    check("stg_busy", busy, 1);
    rst = 1'b1;
    step();
    check("abort_periph", periph_rst_n, 1);
    check("abort_core", core_rst_n, 1);
    check("abort_busy", busy, 0);
    check("abort_count", reset_count, 0);
    check("abort_ack", req_ack, 0);
    check("abort_cause", cause, 0);
    rst = 1'b0;

    // Quiet period: nothing pending survives the abort.
    for (int c = 0; c < 50; c++) begin
      step();
      check("quiet_ack", req_ack, 0);
      check("quiet_busy", busy, 0);
      check("quiet_periph", periph_rst_n, 1);
      check("quiet_core", core_rst_n, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
